branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer.sv | 150 +++++++++++++++
 tb/tb_branch_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Purpose: program-counter sequencer with conditional jumps, relative jumps and a call/return stack.
// Latency: every output is registered; an instruction's effect is visible one cycle after the edge that accepts it.
// Backpressure: none. EN=0 holds the PC and the stack. A faulting CALL or RET advances the PC and sets the sticky STK_ERR.
//
// Ports:
//   CLK, RST         clock; synchronous active-high reset
//   EN               execute one instruction on this edge
//   OP               000 NOP, 001 JMP, 010 JREL, 011 CALL, 100 RET, all other codes act as NOP
//   COND_SEL/INV/ALWAYS  condition = ALWAYS | (FLAGS[SEL] ^ INV)
//   TARGET           absolute target address; for JREL, a two's-complement offset
//   FLAGS_IN/WE      flag register write port, independent of EN
//   PC, FLAGS        registered program counter and flag register
//   DOJUMP           registered pulse, high for one cycle after a taken control op
//   STK_LEVEL        number of return-stack entries in use
//   STK_ERR          sticky stack overflow/underflow flag
module branch_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int FLAG_W      = 8,
   parameter int SEL_W       = $clog2(FLAG_W),
   parameter int STACK_DEPTH = 4
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           EN,
   input  logic [2:0]                     OP,
   input  logic [SEL_W-1:0]               COND_SEL,
   input  logic                           COND_INV,
   input  logic                           COND_ALWAYS,
   input  logic [ADDR_W-1:0]              TARGET,
   input  logic [FLAG_W-1:0]              FLAGS_IN,
   input  logic                           FLAGS_WE,
   output logic [ADDR_W-1:0]              PC,
   output logic [FLAG_W-1:0]              FLAGS,
   output logic                           DOJUMP,
   output logic [$clog2(STACK_DEPTH):0]   STK_LEVEL,
   output logic                           STK_ERR
);

   localparam int STK_W = $clog2(STACK_DEPTH) + 1;
   // A depth of 1 still gets a 1-bit index.
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_JREL = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;

   localparam logic [STK_W-1:0] LVL_FULL = STK_W'(STACK_DEPTH);

   logic [ADDR_W-1:0] r_pc;
   logic [FLAG_W-1:0] r_flags;
   logic [STK_W-1:0]  r_lvl;
   logic              r_dojump;
   logic              r_err;
   logic [ADDR_W-1:0] r_stack [0:(1<<IDX_W)-1];

   logic              w_cond;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [IDX_W-1:0]  w_top_idx;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [STK_W-1:0]  w_lvl_nxt;
   logic              w_push;
   logic              w_jump;
   logic              w_err;

   // The condition uses the registered flags, so a flag write takes effect on the next instruction.
   assign w_cond    = COND_ALWAYS | (r_flags[COND_SEL] ^ COND_INV);
   assign w_pc_inc  = r_pc + ADDR_W'(1);
   // Low bits of (level - 1). The stack is only read when the level is non-zero.
   assign w_top_idx = r_lvl[IDX_W-1:0] - IDX_W'(1);

   always_comb begin
      w_pc_nxt  = r_pc;
      w_lvl_nxt = r_lvl;
      w_push    = 1'b0;
      w_jump    = 1'b0;
      w_err     = 1'b0;
      if (EN) begin
         w_pc_nxt = w_pc_inc;
         case (OP)
            OP_JMP: begin
               if (w_cond) begin
                  w_pc_nxt = TARGET;
                  w_jump   = 1'b1;
               end
            end
            OP_JREL: begin
               // The offset is as wide as the PC, so a modulo-2^ADDR_W add already
               // gives the sign-extended result.
               if (w_cond) begin
                  w_pc_nxt = r_pc + TARGET;
                  w_jump   = 1'b1;
               end
            end
            OP_CALL: begin
               if (w_cond) begin
                  if (r_lvl != LVL_FULL) begin
                     w_push    = 1'b1;
                     w_lvl_nxt = r_lvl + STK_W'(1);
                     w_pc_nxt  = TARGET;
                     w_jump    = 1'b1;
                  end else begin
                     w_err = 1'b1;
                  end
               end
            end
            OP_RET: begin
               if (w_cond) begin
                  if (r_lvl != '0) begin
                     w_lvl_nxt = r_lvl - STK_W'(1);
                     w_pc_nxt  = r_stack[w_top_idx];
                     w_jump    = 1'b1;
                  end else begin
                     w_err = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc     <= '0;
         r_flags  <= '0;
         r_lvl    <= '0;
         r_dojump <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_pc     <= w_pc_nxt;
         r_lvl    <= w_lvl_nxt;
         r_dojump <= w_jump;
         if (FLAGS_WE) r_flags <= FLAGS_IN;
         if (w_err)    r_err   <= 1'b1;
      end
   end

   // Stack storage has no reset. Entries at or above the level are never read.
   always_ff @(posedge CLK) begin
      if (!RST && w_push) r_stack[r_lvl[IDX_W-1:0]] <= w_pc_inc;
   end

   assign PC        = r_pc;
   assign FLAGS     = r_flags;
   assign DOJUMP    = r_dojump;
   assign STK_LEVEL = r_lvl;
   assign STK_ERR   = r_err;

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

   localparam int DEPTH = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       EN = 1'b0;
   logic [2:0] OP = 3'd0;
   logic [2:0] COND_SEL = 3'd0;
   logic       COND_INV = 1'b0;
   logic       COND_ALWAYS = 1'b0;
   logic [7:0] TARGET = 8'd0;
   logic [7:0] FLAGS_IN = 8'd0;
   logic       FLAGS_WE = 1'b0;
   logic [7:0] PC;
   logic [7:0] FLAGS;
   logic       DOJUMP;
   logic [2:0] STK_LEVEL;
   logic       STK_ERR;

   int checks = 0;
   int errors = 0;

   // Reference state
   int m_pc;
   int m_flags;
   int m_stack[$];
   bit m_err;
   bit m_dj;

   always #5 CLK = ~CLK;

   branch_sequencer #(.ADDR_W(8), .FLAG_W(8), .SEL_W(3), .STACK_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .OP(OP), .COND_SEL(COND_SEL), .COND_INV(COND_INV),
      .COND_ALWAYS(COND_ALWAYS), .TARGET(TARGET), .FLAGS_IN(FLAGS_IN), .FLAGS_WE(FLAGS_WE),
      .PC(PC), .FLAGS(FLAGS), .DOJUMP(DOJUMP), .STK_LEVEL(STK_LEVEL), .STK_ERR(STK_ERR)
   );

   // Drive one cycle, advance the reference, then sample 1 time unit after the edge.
   task automatic apply(input bit rst, input bit en, input int op, input int sel, input bit inv,
                        input bit alw, input int tgt, input bit fwe, input int fin);
      int  off;
      bit  cond;
      RST = rst; EN = en; OP = 3'(op); COND_SEL = 3'(sel); COND_INV = inv;
      COND_ALWAYS = alw; TARGET = 8'(tgt); FLAGS_WE = fwe; FLAGS_IN = 8'(fin);
      if (rst) begin
         m_pc = 0; m_flags = 0; m_stack.delete(); m_err = 0; m_dj = 0;
      end else begin
         cond = alw || ((((m_flags >> sel) & 1) != 0) != inv);
         m_dj = 0;
         if (en) begin
            if (op == 1 && cond) begin
               m_pc = tgt; m_dj = 1;
            end else if (op == 2 && cond) begin
               off  = (tgt >= 128) ? tgt - 256 : tgt;
               m_pc = (m_pc + off + 256) % 256; m_dj = 1;
            end else if (op == 3 && cond) begin
               if (m_stack.size() < DEPTH) begin
                  m_stack.push_back((m_pc + 1) % 256); m_pc = tgt; m_dj = 1;
               end else begin
                  m_err = 1; m_pc = (m_pc + 1) % 256;
               end
            end else if (op == 4 && cond) begin
               if (m_stack.size() > 0) begin
                  m_pc = m_stack.pop_back(); m_dj = 1;
               end else begin
                  m_err = 1; m_pc = (m_pc + 1) % 256;
               end
            end else begin
               m_pc = (m_pc + 1) % 256;
            end
         end
         if (fwe) m_flags = fin;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      apply(1, 1, 3, 0, 0, 1, 'h33, 1, 'hAA);
      checks += 5;
      if (PC !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", PC); end
      if (FLAGS !== 8'h00) begin errors++; $display("FAIL reset_flags got %h want 00", FLAGS); end
      if (STK_LEVEL !== 3'd0) begin errors++; $display("FAIL reset_lvl got %0d want 0", STK_LEVEL); end
      if (DOJUMP !== 1'b0) begin errors++; $display("FAIL reset_dojump got %b want 0", DOJUMP); end
      if (STK_ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", STK_ERR); end
   endtask

   task automatic test_nop();
      for (int i = 1; i <= 3; i++) begin
         apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
         checks += 2;
         if (PC !== 8'(i)) begin errors++; $display("FAIL nop_pc got %h want %h", PC, 8'(i)); end
         if (DOJUMP !== 1'b0) begin errors++; $display("FAIL nop_dojump got %b want 0", DOJUMP); end
      end
   endtask

   task automatic test_jmp();
      apply(0, 0, 0, 0, 0, 0, 0, 1, 'h04);
      apply(0, 1, 1, 2, 0, 0, 'h40, 0, 0);
      checks += 2;
      if (PC !== 8'h40) begin errors++; $display("FAIL jmp_taken_pc got %h want 40", PC); end
      if (DOJUMP !== 1'b1) begin errors++; $display("FAIL jmp_taken_dojump got %b want 1", DOJUMP); end
      apply(0, 0, 1, 2, 0, 0, 'h10, 0, 0);
      checks += 2;
      if (DOJUMP !== 1'b0) begin errors++; $display("FAIL jmp_pulse_width got %b want 0", DOJUMP); end
      if (PC !== 8'h40) begin errors++; $display("FAIL en0_hold_pc got %h want 40", PC); end
      apply(0, 1, 1, 2, 1, 0, 'h40, 0, 0);
      checks += 2;
      if (PC !== 8'h41) begin errors++; $display("FAIL jmp_inv_pc got %h want 41", PC); end
      if (DOJUMP !== 1'b0) begin errors++; $display("FAIL jmp_inv_dojump got %b want 0", DOJUMP); end
   endtask

   task automatic test_jrel();
      apply(0, 1, 1, 0, 0, 1, 'h10, 0, 0);
      apply(0, 1, 2, 0, 0, 1, 'hFC, 0, 0);
      checks += 2;
      if (PC !== 8'h0C) begin errors++; $display("FAIL jrel_back_pc got %h want 0c", PC); end
      if (DOJUMP !== 1'b1) begin errors++; $display("FAIL jrel_dojump got %b want 1", DOJUMP); end
      apply(0, 1, 1, 0, 0, 1, 'hFF, 0, 0);
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (PC !== 8'h00) begin errors++; $display("FAIL pc_wrap got %h want 00", PC); end
   endtask

   task automatic test_call_ret();
      int exp_ret[4] = '{8'h81, 8'h81, 8'h81, 8'h06};
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 1, 1, 0, 0, 1, 'h05, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         apply(0, 1, 3, 0, 0, 1, 'h80, 0, 0);
         checks += 2;
         if (STK_LEVEL !== 3'(i)) begin errors++; $display("FAIL call_level got %0d want %0d", STK_LEVEL, i); end
         if (PC !== 8'h80) begin errors++; $display("FAIL call_pc got %h want 80", PC); end
      end
      apply(0, 1, 3, 0, 0, 1, 'h80, 0, 0);
      checks += 4;
      if (PC !== 8'h81) begin errors++; $display("FAIL overflow_pc got %h want 81", PC); end
      if (STK_ERR !== 1'b1) begin errors++; $display("FAIL overflow_err got %b want 1", STK_ERR); end
      if (DOJUMP !== 1'b0) begin errors++; $display("FAIL overflow_dojump got %b want 0", DOJUMP); end
      if (STK_LEVEL !== 3'd4) begin errors++; $display("FAIL overflow_level got %0d want 4", STK_LEVEL); end
      for (int i = 0; i < 4; i++) begin
         apply(0, 1, 4, 0, 0, 1, 0, 0, 0);
         checks += 3;
         if (PC !== 8'(exp_ret[i])) begin errors++; $display("FAIL ret_pc got %h want %h", PC, 8'(exp_ret[i])); end
         if (STK_LEVEL !== 3'(3 - i)) begin errors++; $display("FAIL ret_level got %0d want %0d", STK_LEVEL, 3 - i); end
         if (DOJUMP !== 1'b1) begin errors++; $display("FAIL ret_dojump got %b want 1", DOJUMP); end
      end
      checks++;
      if (STK_ERR !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", STK_ERR); end
   endtask

   task automatic test_ret_empty_and_flags();
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 1, 4, 0, 0, 1, 0, 0, 0);
      checks += 3;
      if (PC !== 8'h01) begin errors++; $display("FAIL underflow_pc got %h want 01", PC); end
      if (STK_ERR !== 1'b1) begin errors++; $display("FAIL underflow_err got %b want 1", STK_ERR); end
      if (DOJUMP !== 1'b0) begin errors++; $display("FAIL underflow_dojump got %b want 0", DOJUMP); end
      apply(0, 1, 1, 2, 0, 0, 'h40, 1, 'h04);
      checks += 3;
      if (PC !== 8'h02) begin errors++; $display("FAIL oldflags_pc got %h want 02", PC); end
      if (DOJUMP !== 1'b0) begin errors++; $display("FAIL oldflags_dojump got %b want 0", DOJUMP); end
      if (FLAGS !== 8'h04) begin errors++; $display("FAIL flags_write got %h want 04", FLAGS); end
      apply(0, 1, 1, 2, 0, 0, 'h40, 0, 0);
      checks++;
      if (PC !== 8'h40) begin errors++; $display("FAIL newflags_pc got %h want 40", PC); end
   endtask

   task automatic test_reset_during_call();
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 1, 3, 0, 0, 1, 'h20, 0, 0);
      apply(0, 1, 3, 0, 0, 1, 'h30, 0, 0);
      checks++;
      if (STK_LEVEL !== 3'd2) begin errors++; $display("FAIL pre_rst_level got %0d want 2", STK_LEVEL); end
      apply(1, 1, 3, 0, 0, 1, 'h50, 0, 0);
      checks += 4;
      if (PC !== 8'h00) begin errors++; $display("FAIL rst_call_pc got %h want 00", PC); end
      if (STK_LEVEL !== 3'd0) begin errors++; $display("FAIL rst_call_level got %0d want 0", STK_LEVEL); end
      if (STK_ERR !== 1'b0) begin errors++; $display("FAIL rst_call_err got %b want 0", STK_ERR); end
      if (DOJUMP !== 1'b0) begin errors++; $display("FAIL rst_call_dojump got %b want 0", DOJUMP); end
      apply(0, 1, 4, 0, 0, 1, 0, 0, 0);
      checks += 2;
      if (STK_ERR !== 1'b1) begin errors++; $display("FAIL rst_discard_err got %b want 1", STK_ERR); end
      if (PC !== 8'h01) begin errors++; $display("FAIL rst_discard_pc got %h want 01", PC); end
   endtask

   task automatic test_random();
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) != 0), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 255), ($urandom_range(0, 3) == 0), $urandom_range(0, 255));
         checks += 5;
         if (PC !== 8'(m_pc)) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", n, PC, 8'(m_pc)); end
         if (FLAGS !== 8'(m_flags)) begin errors++; $display("FAIL rnd_flags cyc %0d got %h want %h", n, FLAGS, 8'(m_flags)); end
         if (STK_LEVEL !== 3'(m_stack.size())) begin errors++; $display("FAIL rnd_level cyc %0d got %0d want %0d", n, STK_LEVEL, m_stack.size()); end
         if (DOJUMP !== m_dj) begin errors++; $display("FAIL rnd_dojump cyc %0d got %b want %b", n, DOJUMP, m_dj); end
         if (STK_ERR !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", n, STK_ERR, m_err); end
      end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_jmp();
      test_jrel();
      test_call_ret();
      test_ret_empty_and_flags();
      test_reset_during_call();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
